// File: rtl/uart_tx.sv
// UART transmitter: 8N1 framing, LSB first, idle-high line, one bit = CLKS_PER_BIT clocks.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       start,
  input  logic [7:0] data_in,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] test_state
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (cnt_q == CNT_MAX);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (start && enable) begin
          shift_d = data_in;
          idx_d   = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = START;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            // tx is registered, so present the bit that is about to reach shift[0]
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          cnt_d   = '0;
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef UART_TX_PARITY_EN
  assign test_state = (state_q == PARITY) ? 2'd2 : state_q[1:0];
`else
  assign test_state = state_q[1:0];
`endif

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frame-level reference model checked every cycle, plus directed literal checks.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx;

  localparam int C = 32;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FL = FB * C;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       start;
  logic [7:0] data_in;
  logic       tx;
  logic       busy;
  logic       done;
  logic [1:0] test_state;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .data_in(data_in),
    .tx(tx), .busy(busy), .done(done), .test_state(test_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers the accepting edge and the frame's bit list.
  int unsigned cyc  = 0;
  int unsigned k    = 0;
  bit          have = 0;
  bit          frame [0:FB-1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have = 0;
    end else begin
      cyc++;
      if ((!have || (cyc - k) > FL) && start === 1'b1 && enable === 1'b1) begin
        have = 1;
        k = cyc;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1+i] = data_in[i];
`ifdef UART_TX_PARITY_EN
        frame[9] = ^data_in;
`endif
        frame[FB-1] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      int unsigned n;
      logic e_tx, e_busy, e_done;
      logic [1:0] e_st;
      n = cyc - k;
      e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_st = 2'd0;
      if (have && n < FL) begin
        e_tx = frame[n / C];
        e_busy = 1'b1;
        if (n / C == 0) e_st = 2'd1;
        else if (n / C == FB - 1) e_st = 2'd3;
        else e_st = 2'd2;
      end else if (have && n == FL) begin
        e_done = 1'b1;
      end
      chk("model_tx", {7'd0, tx}, {7'd0, e_tx});
      chk("model_busy", {7'd0, busy}, {7'd0, e_busy});
      chk("model_done", {7'd0, done}, {7'd0, e_done});
      chk("model_state", {6'd0, test_state}, {6'd0, e_st});
    end
  end

  task automatic pulse_start(input logic [7:0] d);
    @(negedge clk);
    start = 1'b1;
    data_in = d;
    @(negedge clk);
    start = 1'b0;
    data_in = ~d;
  endtask

  // Serial decoder: finds the start bit and samples each bit mid-cell.
  task automatic recv(input string name, output logic [7:0] b, output logic p);
    int w;
    b = '0;
    p = 1'b0;
    w = 0;
    while (tx !== 1'b0 && w < 4 * FL) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) begin
      chk({name, "_start_timeout"}, {7'd0, tx}, 8'd0);
      return;
    end
    repeat (C / 2) @(negedge clk);
    chk({name, "_startbit"}, {7'd0, tx}, 8'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge clk);
      b[i] = tx;
    end
`ifdef UART_TX_PARITY_EN
    repeat (C) @(negedge clk);
    p = tx;
`endif
    repeat (C) @(negedge clk);
    chk({name, "_stopbit"}, {7'd0, tx}, 8'd1);
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < FL + 10) begin
      @(negedge clk);
      w++;
    end
    chk({name, "_idle"}, {7'd0, busy}, 8'd0);
    @(negedge clk);
  endtask

  initial begin
`ifdef UART_TX_PARITY_EN
    bit seq17 [0:FB-1] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 1};
`else
    bit seq17 [0:FB-1] = '{0, 1, 1, 1, 0, 1, 0, 0, 0, 1};
`endif
    logic [7:0] bytes [0:3] = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
    logic [7:0] rb;
    logic       rp;
    int bc, dc, rises, lowrun;
    logic prev;

    rst_n = 1'b0; start = 1'b0; enable = 1'b1; data_in = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_tx", {7'd0, tx}, 8'd1);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_done", {7'd0, done}, 8'd0);
    chk("reset_state", {6'd0, test_state}, 8'd0);
    rst_n = 1'b1;
    cmp_en = 1;
    repeat (2) @(negedge clk);

    // 0x17 frame: literal bit sequence, busy length, single done
    pulse_start(8'h17);
    bc = 0; dc = 0;
    for (int n = 0; n <= FL + 2; n++) begin
      if (busy === 1'b1) bc++;
      if (done === 1'b1) dc++;
      if (n < FL && (n % C) == C / 2) chk($sformatf("seq17_bit%0d", n / C), {7'd0, tx}, {7'd0, seq17[n / C]});
      @(negedge clk);
    end
    chk("busy_cycles_lo", bc[7:0], 8'(FL));
    chk("busy_cycles_hi", 8'(bc >> 8), 8'(FL >> 8));
    chk("done_pulses", dc[7:0], 8'd1);

    // Loopback-style decode of boundary bytes
    for (int i = 0; i < 4; i++) begin
      pulse_start(bytes[i]);
      recv("loop", rb, rp);
      chk($sformatf("loop_byte%0d", i), rb, bytes[i]);
      wait_idle("loop");
    end

    // start held high for 700 clocks
    @(negedge clk);
    start = 1'b1;
    data_in = 8'h3C;
    rises = 0; lowrun = 0; prev = 1'b0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (busy === 1'b1 && prev === 1'b0) begin
        rises++;
        if (rises > 1) chk("held_gap", lowrun[7:0], 8'd1);
        lowrun = 0;
      end
      if (busy !== 1'b1) lowrun++;
      prev = busy;
    end
    chk("held_frames", rises[7:0], 8'd3);
    start = 1'b0;
    wait_idle("held");

    // enable low blocks acceptance
    enable = 1'b0;
    pulse_start(8'h55);
    repeat (20) @(negedge clk);
    chk("disabled_tx", {7'd0, tx}, 8'd1);
    chk("disabled_busy", {7'd0, busy}, 8'd0);
    enable = 1'b1;

    // enable dropped mid-frame: frame completes
    pulse_start(8'h96);
    repeat (100) @(negedge clk);
    enable = 1'b0;
    dc = 0;
    for (int n = 0; n < FL; n++) begin
      @(negedge clk);
      if (done === 1'b1) dc++;
    end
    chk("enable_drop_done", dc[7:0], 8'd1);
    enable = 1'b1;

    // asynchronous reset mid-frame, then a clean frame
    pulse_start(8'h81);
    repeat (150) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", {7'd0, tx}, 8'd1);
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    chk("async_rst_state", {6'd0, test_state}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(8'h81);
    recv("after_rst", rb, rp);
    chk("after_rst_byte", rb, 8'h81);
    wait_idle("after_rst");

`ifdef UART_TX_PARITY_EN
    pulse_start(8'h17);
    recv("par17", rb, rp);
    chk("par17_byte", rb, 8'h17);
    chk("par17_parity", {7'd0, rp}, 8'd0);
    wait_idle("par17");
    pulse_start(8'h07);
    recv("par07", rb, rp);
    chk("par07_byte", rb, 8'h07);
    chk("par07_parity", {7'd0, rp}, 8'd1);
    wait_idle("par07");
`endif

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Byte-serial UART transmitter, 8N1 framing (optional even parity), LSB first, idle-high line. It is the transmit-side counterpart of the existing UART_RX and shares its bit timing: one bit lasts CLKS_PER_BIT clocks of `clk`. A host loads a byte with a single-cycle `start` strobe and gets a one-cycle `done` pulse when the stop bit has finished. The block drives the neural-network result path back to the PC.

## Interface
- `CLKS_PER_BIT`, default 32: clocks per serial bit; legal range 2..65535. Must match UART_RX.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `enable`  in  1  gates acceptance of new frames; a frame already in progress always completes.
- `start`  in  1  load strobe; sampled only in IDLE with `enable`=1.
- `data_in`  in  8  byte to send; captured on the accepting edge.
- `tx`  out  1  serial line; reset value 1.
- `busy`  out  1  high while a frame is on the line; reset value 0.
- `done`  out  1  one-cycle pulse at end of frame; reset value 0.
- `test_state`  out  2  current FSM state, for debug: IDLE=0, START=1, DATA=2, STOP=3; reset value 0.

## Operation
- FSM states: IDLE, START, DATA, STOP. A PARITY state exists only when parity is enabled (see Configuration). With parity compiled in, `test_state` reads 2 during the parity bit.
- IDLE: `tx`=1, `busy`=0. When `start`=1 and `enable`=1 at an edge:
  - load `data_in` into the shift register;
  - clear the bit counter;
  - `tx`<=0, `busy`<=1;
  - go to START.
- START: hold `tx`=0 for CLKS_PER_BIT clocks, then go to DATA.
- DATA: drive `shift[0]`, shifting right every CLKS_PER_BIT clocks. After 8 bits go to STOP (or PARITY when enabled).
- STOP: hold `tx`=1 for CLKS_PER_BIT clocks. At the last clock, at the same edge:
  - `done`<=1 for exactly one cycle;
  - `busy`<=0;
  - state<=IDLE.
- `start` is ignored while `busy`=1 or `enable`=0. It is not queued.
- Changes to `data_in` after the accepting edge have no effect on the frame in progress.
- Clock-divider counter width is $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary.
- A 3-bit index counts data bits 0..7.
- `tx` is registered: no combinational path from any input to `tx`.
- Reset asserted mid-frame, asynchronously:
  - `tx`=1, `busy`=0, `done`=0, state=IDLE;
  - all counters cleared.
  - The truncated frame is not resumed.

## Timing
- Let edge k accept `start`, and C=CLKS_PER_BIT.
- Start bit: `tx`=0 from edge k through edge k+C.
- Data bit i (i=0..7): on the line from edge k+(1+i)·C.
- Stop bit: from edge k+9·C.
- At edge k+10·C: `done`=1, `busy`=0.
- `busy` stays high for exactly 10·C cycles (11·C with parity).
- Start-to-line latency is 1 cycle.
- The earliest next accept is edge k+10·C+1. Back-to-back frames therefore have exactly one idle-high clock between the stop bit and the next start bit.
- `start` held high continuously sends the same byte repeatedly with that one-cycle gap.
- `enable` dropping mid-frame: the frame finishes normally and `done` still pulses.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - a PARITY state follows DATA;
  - it sends one even-parity bit (XOR of the 8 data bits) for C clocks;
  - frame length is 11·C.
- Undefined: pure 8N1, 10·C frame, no parity logic synthesized.
- The macro must be set identically for UART_RX's companion build.

## Test plan
- Reset, `CLKS_PER_BIT`=32, `data_in`=0x17, `start` pulse -> `tx` sequence 0,1,1,1,0,1,0,0,0,1, each held 32 clocks. `busy` high for 320 clocks, `done` one pulse at edge k+320.
- Loopback into UART_RX (same clk, C=32) with bytes 0x00, 0xFF, 0xA5, 0x5A -> UART_RX `data_out` matches each byte and raises `done` once per byte.
- `start` held high for 700 clocks with 0x3C -> two complete frames and a third in progress. Exactly one idle clock between frames; `start` during `busy` is never latched early.
- `enable`=0 with `start` pulse -> `tx` stays 1, `busy` stays 0. Deassert `enable` at clock 100 of a frame -> the frame completes and `done` pulses.
- `rst_n` pulled low at clock 150 of a 0x81 frame -> `tx`=1 and `busy`=0 immediately, with no clock edge needed. A new `start` after release sends a clean frame.
- With `UART_TX_PARITY_EN`, 0x17 -> parity bit 0. With 0x07 -> parity bit 1. Frame length is 352 clocks.
